ram_valid_dp: RTL and testbench
===============================

# ram_valid_dp

Parametrised simple dual-port RAM with per-word valid tracking, registered read port, occupancy count and a hardware clear sequencer. It replaces the single-address, combinational-read RAM in storage paths that need concurrent read/write addressing, a known-clean state after reset, and a bulk clear without software loops. It sits between a producer that writes records and a consumer that looks them up by address.

## Interface
- AW, 4: address width; depth is 2**AW words.
- DW, 8: data word width.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_en_i  in  1  write request.
- wr_addr_i  in  AW  write address.
- wr_data_i  in  DW  write data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  read address.
- rd_data_o  out  DW  registered read data.
- rd_valid_o  out  1  one-cycle strobe; rd_data_o/rd_hit_o updated this cycle.
- rd_hit_o  out  1  addressed word was valid at read time.
- clr_i  in  1  start bulk clear.
- busy_o  out  1  clear sequence in progress.
- valid_cnt_o  out  AW+1  number of valid words, 0..2**AW.

## Operation
- Storage: mem[0:2**AW-1] of DW bits, valid[0:2**AW-1]. mem has no reset; valid resets to all 0.
- Accept condition: accept = !busy_o && !clr_i. Writes and reads are ignored unless accepted.
- Write (wr_en_i && accept): mem[wr_addr_i] <= wr_data_i, valid[wr_addr_i] <= 1. valid_cnt_o increments by 1 only if the word was previously invalid; overwrites leave the count unchanged.
- Read (rd_en_i && accept): next cycle rd_valid_o=1, rd_hit_o=valid[rd_addr_i], rd_data_o = mem[rd_addr_i] if valid, else all zeros.
- Read-during-write, same address, same cycle: write-first bypass; rd_data_o=wr_data_i, rd_hit_o=1. Different addresses: independent.
- No accepted read: rd_valid_o=0; rd_data_o and rd_hit_o hold their previous values.
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clr_i=1: in that same edge, all valid bits go to 0, valid_cnt_o goes to 0, the sweep counter goes to 0, and the state moves to CLEAR. Any wr_en_i/rd_en_i in that cycle is dropped.
  - CLEAR: each cycle mem[cnt] <= 0 and cnt increments. After the write to cnt = 2**AW-1, the state returns to IDLE. Counter wraps to 0.
  - clr_i while in CLEAR is ignored; the sweep is not restarted.
- busy_o=1 exactly while in CLEAR. In CLEAR, reads and writes are dropped, rd_valid_o=0, and valid_cnt_o stays 0.
- Reset, including mid-clear: state IDLE, cnt=0, valid all 0, valid_cnt_o=0, busy_o=0, rd_valid_o=0, rd_hit_o=0, rd_data_o=0. A partially swept mem keeps arbitrary contents; it is masked by the valid bits.

## Timing
- Write: mem and valid updated at the accepting edge. A read accepted on the following cycle returns the new data.
- Read latency: 1 cycle, from the accepting edge to rd_valid_o high.
- Throughput: one read plus one write per cycle when idle.
- Clear: clr_i sampled at edge T0; busy_o is high from T0 through T0 + 2**AW cycles (2**AW sweep cycles). busy_o is low, and accesses are accepted again, on the cycle after the last sweep write.
- valid_cnt_o is registered and reflects all writes accepted up to the previous edge.

## Test plan
- Reset then read: assert rst_i; read addresses 0..15 after release -> every read gives rd_valid_o=1 one cycle later, rd_hit_o=0, rd_data_o=8'h00, valid_cnt_o=0.
- Write/read back: write addr i with data 8'hA0+i for i=0..15, then read all -> rd_data_o=8'hA0+i, rd_hit_o=1, valid_cnt_o=16. Rewriting addr 3 with 8'h55 leaves the count at 16 and a read returns 8'h55.
- Bypass: same cycle write addr 5 = 8'h3C and read addr 5 -> next cycle rd_data_o=8'h3C, rd_hit_o=1. Write addr 6 and read addr 7 in the same cycle -> the read returns addr 7's old value.
- Clear: fill all 16 words, pulse clr_i for one cycle -> busy_o high for 16 cycles, valid_cnt_o=0 the cycle after clr_i. Reads and writes issued while busy have no effect and rd_valid_o stays 0. After clear, reads give rd_hit_o=0 and data 8'h00.
- Collision with clear: clr_i together with a write of addr 2 = 8'hFF and a read of addr 2 -> the write is dropped, rd_valid_o=0, and after the clear addr 2 reads as a miss. clr_i re-pulsed mid-sweep -> busy_o still deasserts 16 cycles after the first pulse.
- Reset mid-clear: assert rst_i 5 cycles into the sweep -> busy_o=0 immediately and all outputs at reset values. Writing addr 9 = 8'h12 afterwards reads back 8'h12 with hit and valid_cnt_o=1.

Source files
------------

// File: rtl/ram_valid_dp_if.sv
// Bus bundle for ram_valid_dp: producer write port, consumer read port,
// bulk-clear control and status. The master drives requests, the slave
// (the RAM) returns read data and status.
interface ram_valid_dp_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_hit_o;
  logic          clr_i;
  logic          busy_o;
  logic [AW:0]   valid_cnt_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, clr_i,
    input  rd_data_o, rd_valid_o, rd_hit_o, busy_o, valid_cnt_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, clr_i,
    output rd_data_o, rd_valid_o, rd_hit_o, busy_o, valid_cnt_o
  );
endinterface

// File: rtl/ram_valid_dp.sv
// Simple dual-port RAM with per-word valid bits, a registered read port,
// an occupancy counter and a hardware clear sequencer. The data array has
// no reset; the valid bits are what make the contents trustworthy, so a
// clear drops them all at once and then sweeps the array to zero.
module ram_valid_dp #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ram_valid_dp_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [DEPTH-1:0] valid;
  logic [AW:0]   valid_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_hit;

  logic accept;
  logic wr_acc;
  logic rd_acc;
  logic bypass;
  logic wr_new;

  // Accesses are only honoured when no clear is running or being started.
  assign accept = (state == IDLE) && !bus.clr_i;
  assign wr_acc = accept && bus.wr_en_i;
  assign rd_acc = accept && bus.rd_en_i;
  assign bypass = wr_acc && (bus.wr_addr_i == bus.rd_addr_i);
  assign wr_new = wr_acc && !valid[bus.wr_addr_i];

  assign bus.rd_data_o   = rd_data;
  assign bus.rd_valid_o  = rd_valid;
  assign bus.rd_hit_o    = rd_hit;
  assign bus.busy_o      = (state == CLEAR);
  assign bus.valid_cnt_o = valid_cnt;

  // Data array: the sweep owns the write port while clearing, otherwise
  // accepted producer writes land here.
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  // Registered read port with write-first bypass; invalid words read as
  // zero so stale contents never leak out. Outputs hold without a read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        if (bypass) begin
          rd_hit  <= 1'b1;
          rd_data <= bus.wr_data_i;
        end else if (valid[bus.rd_addr_i]) begin
          rd_hit  <= 1'b1;
          rd_data <= mem[bus.rd_addr_i];
        end else begin
          rd_hit  <= 1'b0;
          rd_data <= '0;
        end
      end
    end
  end

  // Clear sequencer plus valid-bit and occupancy bookkeeping; starting a
  // clear invalidates everything in one edge, the sweep then zeroes mem.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      valid_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_i) begin
            state     <= CLEAR;
            cnt       <= '0;
            valid     <= '0;
            valid_cnt <= '0;
          end else if (wr_acc) begin
            valid[bus.wr_addr_i] <= 1'b1;
            if (wr_new) begin
              valid_cnt <= valid_cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_valid_dp.sv
// Self-checking bench for ram_valid_dp: a constant vector table for the
// basic read/write/bypass behaviour, hand sequences for clear and reset
// corner cases, and a randomized run against an array-based model.
module tb_ram_valid_dp;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  ram_valid_dp_if #(.AW(AW), .DW(DW)) bus ();

  ram_valid_dp #(.AW(AW), .DW(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          exp_rv;
    logic          exp_hit;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t vecs [8];

  int total  = 0;
  int passed = 0;

  // Reference model: plain arrays plus a countdown of remaining clear cycles.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_valid [DEPTH];
  int            busy_left;
  logic          m_rv;
  logic          m_hit;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic int modelCount();
    int c = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (m_valid[j]) c++;
    end
    return c;
  endfunction

  task automatic modelReset();
    for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
    busy_left = 0;
    m_rv      = 1'b0;
    m_hit     = 1'b0;
    m_data    = '0;
  endtask

  task automatic modelStep(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic re, input logic [AW-1:0] ra, input logic clr);
    bit acc;
    acc  = (busy_left == 0) && !clr;
    m_rv = acc && re;
    if (acc && re) begin
      if (we && (wa == ra)) begin
        m_hit  = 1'b1;
        m_data = wd;
      end else begin
        m_hit  = m_valid[ra];
        m_data = m_valid[ra] ? m_mem[ra] : '0;
      end
    end
    if (acc && we) begin
      m_mem[wa]   = wd;
      m_valid[wa] = 1'b1;
    end
    if (busy_left > 0) begin
      busy_left--;
    end else if (clr) begin
      for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
      busy_left = DEPTH;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic re, input logic [AW-1:0] ra, input logic clr);
    bus.wr_en_i   = we;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    bus.rd_en_i   = re;
    bus.rd_addr_i = ra;
    bus.clr_i     = clr;
    @(posedge clk_i);
    modelStep(we, wa, wd, re, ra, clr);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.clr_i   = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    check({name, " rd_valid"}, 32'(bus.rd_valid_o), 32'(m_rv));
    check({name, " rd_hit"}, 32'(bus.rd_hit_o), 32'(m_hit));
    check({name, " rd_data"}, 32'(bus.rd_data_o), 32'(m_data));
    check({name, " valid_cnt"}, 32'(bus.valid_cnt_o), 32'(modelCount()));
    check({name, " busy"}, 32'(bus.busy_o), 32'(busy_left > 0));
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();
  endtask

  initial begin
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.rd_en_i   = 1'b0;
    bus.rd_addr_i = '0;
    bus.clr_i     = 1'b0;

    //            we    wa     wd     re    ra     rv    hit   data   cnt
    vecs[0] = '{1'b1, 4'd0, 8'h11, 1'b1, 4'd0, 1'b1, 1'b1, 8'h11, 5'd1};
    vecs[1] = '{1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b1, 1'b1, 8'h3C, 5'd2};
    vecs[2] = '{1'b1, 4'd6, 8'h77, 1'b1, 4'd7, 1'b1, 1'b0, 8'h00, 5'd3};
    vecs[3] = '{1'b1, 4'd3, 8'h55, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 5'd4};
    vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 1'b1, 8'h55, 5'd4};
    vecs[5] = '{1'b1, 4'd3, 8'h66, 1'b1, 4'd6, 1'b1, 1'b1, 8'h77, 5'd4};
    vecs[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 1'b1, 8'h66, 5'd4};
    vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 8'h66, 5'd4};

    $display("[TB] reset and read-after-reset");
    doReset();
    check("reset rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("reset rd_data", 32'(bus.rd_data_o), 32'd0);
    check("reset valid_cnt", 32'(bus.valid_cnt_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
      check("rst read rd_valid", 32'(bus.rd_valid_o), 32'd1);
      check("rst read rd_hit", 32'(bus.rd_hit_o), 32'd0);
      check("rst read rd_data", 32'(bus.rd_data_o), 32'd0);
      check("rst read valid_cnt", 32'(bus.valid_cnt_o), 32'd0);
    end

    $display("[TB] vector table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].ra, 1'b0);
      check($sformatf("vec%0d rd_valid", v), 32'(bus.rd_valid_o), 32'(vecs[v].exp_rv));
      check($sformatf("vec%0d rd_hit", v), 32'(bus.rd_hit_o), 32'(vecs[v].exp_hit));
      check($sformatf("vec%0d rd_data", v), 32'(bus.rd_data_o), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d valid_cnt", v), 32'(bus.valid_cnt_o), 32'(vecs[v].exp_cnt));
    end

    $display("[TB] fill and read back");
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, AW'(i), DW'(8'hA0 + i), 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
      check("fill rd_data", 32'(bus.rd_data_o), 32'(8'hA0 + i));
      check("fill rd_hit", 32'(bus.rd_hit_o), 32'd1);
      check("fill valid_cnt", 32'(bus.valid_cnt_o), 32'd16);
    end
    applyStimulus(1'b1, 4'd3, 8'h55, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
    check("rewrite rd_data", 32'(bus.rd_data_o), 32'h55);
    check("rewrite valid_cnt", 32'(bus.valid_cnt_o), 32'd16);

    $display("[TB] clear with accesses and re-pulse while busy");
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("clr start busy", 32'(bus.busy_o), 32'd1);
    check("clr start valid_cnt", 32'(bus.valid_cnt_o), 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b1, AW'(k - 1), 8'hEE, 1'b1, AW'(k - 1), 1'(k == 5));
      check($sformatf("clr k%0d busy", k), 32'(bus.busy_o), 32'(k < DEPTH));
      check("clr rd_valid", 32'(bus.rd_valid_o), 32'd0);
      check("clr valid_cnt", 32'(bus.valid_cnt_o), 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
      check("post clr rd_hit", 32'(bus.rd_hit_o), 32'd0);
      check("post clr rd_data", 32'(bus.rd_data_o), 32'd0);
      checkOutput("post clr");
    end

    $display("[TB] clear colliding with access");
    applyStimulus(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2, 1'b1);
    check("collide rd_valid", 32'(bus.rd_valid_o), 32'd0);
    repeat (DEPTH) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("collide done busy", 32'(bus.busy_o), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0);
    check("collide rd_hit", 32'(bus.rd_hit_o), 32'd0);
    check("collide rd_data", 32'(bus.rd_data_o), 32'd0);

    $display("[TB] reset mid-clear");
    applyStimulus(1'b1, 4'd4, 8'hAB, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd4, 1'b0);
    check("pre rst rd_data", 32'(bus.rd_data_o), 32'hAB);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (5) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("mid clr busy", 32'(bus.busy_o), 32'd1);
    rst_i = 1'b1;
    #2;
    check("mid rst busy", 32'(bus.busy_o), 32'd0);
    check("mid rst rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("mid rst rd_hit", 32'(bus.rd_hit_o), 32'd0);
    check("mid rst rd_data", 32'(bus.rd_data_o), 32'd0);
    check("mid rst valid_cnt", 32'(bus.valid_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();
    applyStimulus(1'b1, 4'd9, 8'h12, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd9, 1'b0);
    check("after rst rd_data", 32'(bus.rd_data_o), 32'h12);
    check("after rst rd_hit", 32'(bus.rd_hit_o), 32'd1);
    check("after rst valid_cnt", 32'(bus.valid_cnt_o), 32'd1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                    DW'($urandom), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 59) == 0));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
